uart_boot_loader: RTL and testbench

//  Bus initiator: receives a program image over UART and writes it word-by-word into the

---
 rtl/uart_boot_loader.sv | 203 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image over 8N1 serial and writes it
// word-by-word into the core memory port while holding the CPU in reset.
module uart_boot_loader #(
    parameter int unsigned CLK_HZ    = 60_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        uart_rx,
    output logic [31:0] core_addr,
    output logic [31:0] core_wr_data,
    output logic        core_wr_ena,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int          CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(HALF_BIT - 1);
    localparam logic [15:0]   LEN_MAX    = 16'(MAX_WORDS);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    // ---------------- UART receiver ----------------
    // [0],[1] synchroniser, [2] previous synchronised sample for edge detection
    logic [2:0]    rx_sync_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;
    logic          rx_s, rx_fall;

    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_s;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        bv_d       = 1'b0;
        fe_d       = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == CNT_FULL) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (rx_cnt_q == CNT_FULL) begin
                rx_st_d = RX_IDLE;
                bv_d    = rx_s;
                fe_d    = ~rx_s;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 3'b111;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            bv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            bv_q       <= bv_d;
            fe_q       <= fe_d;
        end
    end

    // ---------------- Frame FSM ----------------
    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] len_full;
    logic [15:0] idx_inc;

    assign len_full = {rx_shift_q, len_q[7:0]};
    assign idx_inc  = idx_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        chk_d   = chk_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: if (bv_q && ena && rx_shift_q == 8'hA5) begin
                state_d = S_LEN0;
                chk_d   = '0;
                idx_d   = '0;
                bcnt_d  = '0;
            end
            S_LEN0: if (fe_q) state_d = S_ERR;
                else if (bv_q) begin
                    len_d   = {8'h00, rx_shift_q};
                    chk_d   = chk_q ^ rx_shift_q;
                    state_d = S_LEN1;
                end
            S_LEN1: if (fe_q) state_d = S_ERR;
                else if (bv_q) begin
                    len_d = len_full;
                    chk_d = chk_q ^ rx_shift_q;
                    if (len_full > LEN_MAX)  state_d = S_ERR;
                    else if (len_full == '0) state_d = S_CHECK;
                    else                     state_d = S_DATA;
                end
            S_DATA: if (fe_q) state_d = S_ERR;
                else if (bv_q) begin
                    // address/data are latched here so the strobe lands on the very next cycle
                    word_d = {rx_shift_q, word_q[31:8]};
                    chk_d  = chk_q ^ rx_shift_q;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        data_d  = word_d;
                        state_d = S_WRITE;
                    end
                end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc < len_q) ? S_DATA : S_CHECK;
            end
            S_CHECK: if (fe_q) state_d = S_ERR;
                else if (bv_q) state_d = (rx_shift_q == chk_q) ? S_DONE : S_ERR;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            chk_q   <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign core_addr    = addr_q;
    assign core_wr_data = data_q;
    assign core_wr_ena  = (state_q == S_WRITE);
    assign core_hold    = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: 10 clk/bit serial stimulus, write-strobe log checked
// against hand-computed addresses and data.
module tb_uart_boot_loader;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        uart_rx;
    logic [31:0] core_addr, core_wr_data;
    logic        core_wr_ena, core_hold, busy, done, error;

    int n_asrt = 0;
    int n_fail = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    uart_boot_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .BASE_ADDR(BASE), .MAX_WORDS(256)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .uart_rx(uart_rx),
        .core_addr(core_addr), .core_wr_data(core_wr_data), .core_wr_ena(core_wr_ena),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // each logged entry is one strobed cycle, so a stretched strobe shows up as an extra write
    always @(negedge clk)
        if (!rst && core_wr_ena) begin
            wr_a.push_back(core_addr);
            wr_d.push_back(core_wr_data);
        end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        idle(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(10);
        end
        uart_rx = stop;
        idle(10);
        uart_rx = 1'b1;
        idle(10);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
    endtask

    logic [7:0] f1 [12];
    int base;

    initial begin
        f1 = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        rst = 1'b1; ena = 1'b1; uart_rx = 1'b1;
        idle(3);
        #1;
        check_eq("rst_addr", core_addr, BASE);
        check_eq("rst_data", core_wr_data, 32'h0);
        check_eq("rst_wr", {31'd0, core_wr_ena}, 32'd0);
        check_eq("rst_hold", {31'd0, core_hold}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, error}, 32'd0);
        rst = 1'b0;
        idle(3);

        // sync byte ignored while ena=0
        ena = 1'b0;
        send_byte(8'hA5, 1'b1);
        check_eq("ena0_busy", {31'd0, busy}, 32'd0);
        ena = 1'b1;

        // 1: good two-word load
        base = wr_a.size();
        for (int i = 0; i < 12; i++) begin
            send_byte(f1[i], 1'b1);
            if (i == 2) check_eq("t1_busy_mid", {31'd0, busy}, 32'd1);
        end
        check_eq("t1_nwr", wr_a.size() - base, 32'd2);
        if (wr_a.size() - base == 2) begin
            check_eq("t1_a0", wr_a[base], BASE);
            check_eq("t1_d0", wr_d[base], 32'h1234_5678);
            check_eq("t1_a1", wr_a[base+1], BASE + 32'd4);
            check_eq("t1_d1", wr_d[base+1], 32'hDEAD_BEEF);
        end
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_hold", {31'd0, core_hold}, 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_err", {31'd0, error}, 32'd0);

        // 2: bad checksum, writes still happen
        do_reset();
        base = wr_a.size();
        for (int i = 0; i < 11; i++) send_byte(f1[i], 1'b1);
        send_byte(8'h29, 1'b1);
        check_eq("t2_nwr", wr_a.size() - base, 32'd2);
        check_eq("t2_err", {31'd0, error}, 32'd1);
        check_eq("t2_done", {31'd0, done}, 32'd0);
        check_eq("t2_hold", {31'd0, core_hold}, 32'd1);

        // 3: LEN=257 exceeds MAX_WORDS
        do_reset();
        base = wr_a.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        check_eq("t3_err", {31'd0, error}, 32'd1);
        check_eq("t3_busy", {31'd0, busy}, 32'd0);
        check_eq("t3_nwr", wr_a.size() - base, 32'd0);

        // 4: noise bytes and a short glitch ahead of a good frame
        do_reset();
        base = wr_a.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(20);
        check_eq("t4_busy_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 12; i++) send_byte(f1[i], 1'b1);
        check_eq("t4_nwr", wr_a.size() - base, 32'd2);
        if (wr_a.size() - base == 2) begin
            check_eq("t4_a0", wr_a[base], BASE);
            check_eq("t4_d1", wr_d[base+1], 32'hDEAD_BEEF);
        end
        check_eq("t4_done", {31'd0, done}, 32'd1);

        // 5: framing error on first data byte
        do_reset();
        base = wr_a.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b0);
        check_eq("t5_err", {31'd0, error}, 32'd1);
        check_eq("t5_nwr", wr_a.size() - base, 32'd0);

        // 6: reset mid-frame, then a clean reload from BASE
        do_reset();
        base = wr_a.size();
        for (int i = 0; i < 8; i++) send_byte(f1[i], 1'b1);
        check_eq("t6_busy_pre", {31'd0, busy}, 32'd1);
        check_eq("t6_nwr_pre", wr_a.size() - base, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_addr", core_addr, BASE);
        check_eq("t6_rst_data", core_wr_data, 32'h0);
        check_eq("t6_rst_hold", {31'd0, core_hold}, 32'd1);
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        idle(3);
        rst = 1'b0;
        idle(3);
        base = wr_a.size();
        for (int i = 0; i < 12; i++) send_byte(f1[i], 1'b1);
        check_eq("t6_nwr", wr_a.size() - base, 32'd2);
        if (wr_a.size() - base == 2) begin
            check_eq("t6_a0", wr_a[base], BASE);
            check_eq("t6_d0", wr_d[base], 32'h1234_5678);
        end
        check_eq("t6_done", {31'd0, done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
